fft_peak_tracker: RTL
=====================

# fft_peak_tracker

Parametrised successor to the single-peak FFT decoder. After each completed FFT frame it sweeps the FFT output memory over a configurable bin range and computes an |re|+|im| magnitude per bin. It keeps a sorted list of the NPEAKS strongest bins above a threshold and converts the strongest bin to a frequency in Hz. A per-frame stability flag is raised once the dominant bin has repeated for STABLE_FRAMES consecutive frames. It sits between the fft core (read port `add_rd`/`dout`) and the note lookup.

## Interface
Parameters
- BIT_WIDTH, 16: width of each real/imag component.
- N, 9: log2(FFT_SIZE); width of bin addresses.
- FFT_SIZE, 512: FFT length; must equal 2^N.
- FS, 48000: sample rate in Hz; must be < 2^16.
- NPEAKS, 2: number of tracked peaks, 1..4.
- MIN_BIN, 1: first scanned bin; bins below it (DC) are skipped.
- THRESH, 64: minimum magnitude for a bin to be considered.
- STABLE_FRAMES, 3: consecutive identical top bins required for `stable`.

Ports
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- fft_done  in  1  one-cycle pulse: frame ready in FFT memory.
- fft_result  in  2*BIT_WIDTH  read data; [2*BIT_WIDTH-1:BIT_WIDTH] = real, [BIT_WIDTH-1:0] = imag, both signed two's complement.
- add_rd  out  N  FFT memory read address.
- busy  out  1  high from the cycle after an accepted fft_done through REPORT.
- peak_valid  out  1  one-cycle pulse: all peak outputs updated.
- peak_count  out  3  number of filled peak slots, 0..NPEAKS.
- peak_bin  out  NPEAKS*N  slot k at [k*N +: N]; slot 0 is strongest.
- peak_mag  out  NPEAKS*(BIT_WIDTH+1)  magnitudes, same ordering.
- frequency  out  BIT_WIDTH+1  Hz of slot 0; 0 if peak_count = 0.
- stable  out  1  dominant bin has held for STABLE_FRAMES frames.

## Operation
- Magnitude: |re|+|im| is unsigned BIT_WIDTH+1 bits. |-2^(BIT_WIDTH-1)| = 2^(BIT_WIDTH-1) exactly, with no saturation.
- Scanned bins run from MIN_BIN to FFT_SIZE/2-1 inclusive, giving M = FFT_SIZE/2 - MIN_BIN bins.
- States:
  - IDLE: waits for fft_done.
  - SCAN: M cycles, issuing one address per cycle.
  - DRAIN: 1 cycle, consumes the last read datum.
  - CALC: 1 cycle, computes frequency.
  - REPORT: 1 cycle, updates outputs; then returns to IDLE.
- fft_done outside IDLE is ignored, with no queuing.
- Working peak list is cleared on entry to SCAN.
- Insertion, for each datum with mag >= THRESH:
  - The bin is inserted at the first slot whose magnitude it strictly exceeds, or into the first empty slot.
  - Lower slots shift down by one and the last slot is dropped.
  - Ties keep the earlier (lower) bin ahead.
- frequency = (peak_bin[0] * FS) >> N, truncated. Product width is N+16 bits; the result fits in BIT_WIDTH+1 bits for the defaults.
- Stability counter, applied at REPORT, 0..STABLE_FRAMES saturating:
  - peak_count = 0: counter goes to 0.
  - Else, top bin equals the previous frame's top bin and the previous frame had peak_count >= 1: counter increments.
  - Else: counter goes to 1.
  - stable = (counter == STABLE_FRAMES).
- Outputs peak_count, peak_bin, peak_mag, frequency and stable change only at REPORT. They hold between frames.

## Timing
- Cycle 0: fft_done sampled high in IDLE.
- Cycles 1..M: SCAN, with add_rd = MIN_BIN + (cycle-1) and busy = 1.
- fft_result for an address is valid the cycle after that address is presented (1-cycle RAM latency).
- Cycle M+1: DRAIN. Cycle M+2: CALC. Cycle M+3: REPORT; peak_valid = 1 and outputs are updated in the same cycle.
- busy falls at M+4. A new fft_done is accepted from cycle M+4.
- For defaults M = 255, so peak_valid appears 258 cycles after fft_done.
- add_rd = 0 outside SCAN.
- Reset values (reset = 0 at a clock edge): state IDLE and all outputs 0. This covers add_rd, busy, peak_valid, peak_count, peak_bin, peak_mag, frequency, stable, the stability counter and the previous top bin.
- Reset asserted mid-scan aborts the frame with no peak_valid. The block is in IDLE the cycle after reset deasserts.
- fft_done coincident with reset deasserting edge: ignored (reset wins).

## Test plan
- Single tone: bin 10 at re=1000, im=-500 (mag 1500), all others 0. Expect at cycle 258: peak_valid, peak_count=1, peak_bin[0]=10, peak_mag[0]=1500, frequency=937.
- Two peaks: bin 20 mag 3000 and bin 40 mag 5000. Expect slot0=40/5000, slot1=20/3000, count=2, frequency=3750.
- Tie and overflow, NPEAKS=2: bins 5, 6, 7 all mag 800. Expect slot0=5, slot1=6 and bin 7 dropped. Also bin 3 at re=-32768, im=-32768 gives mag 65536 in slot 0.
- Threshold and DC: bin 0 mag 30000, all others mag 63. Expect count=0, frequency=0, stable=0, with add_rd never equal to 0 during SCAN.
- Stability: four frames with top bin 10, 10, 10, 12. Expect stable = 0, 0, 1, 0. A fifth frame with no peaks gives stable=0.
- Robustness: fft_done pulsed at cycle 100 of a scan is ignored, giving one peak_valid only. Reset low at cycle 50 of a scan gives no peak_valid and all outputs 0. The next fft_done then completes normally at +258.

Source files
------------

// File: rtl/fft_peak_tracker.sv
// Post-FFT peak tracker: sweeps the FFT read port once per frame and keeps a sorted list of the
// strongest bins. It also reports the top bin as a frequency and flags a steady dominant bin.
module fft_peak_tracker #(
  parameter int unsigned BIT_WIDTH     = 16,
  parameter int unsigned N             = 9,
  parameter int unsigned FFT_SIZE      = 512,
  parameter int unsigned FS            = 48000,
  parameter int unsigned NPEAKS        = 2,
  parameter int unsigned MIN_BIN       = 1,
  parameter int unsigned THRESH        = 64,
  parameter int unsigned STABLE_FRAMES = 3
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            fft_done,
  input  logic [2*BIT_WIDTH-1:0]          fft_result,
  output logic [N-1:0]                    add_rd,
  output logic                            busy,
  output logic                            peak_valid,
  output logic [2:0]                      peak_count,
  output logic [NPEAKS*N-1:0]             peak_bin,
  output logic [NPEAKS*(BIT_WIDTH+1)-1:0] peak_mag,
  output logic [BIT_WIDTH:0]              frequency,
  output logic                            stable
);

  localparam int unsigned MW      = BIT_WIDTH + 1;
  localparam int unsigned LastBin = FFT_SIZE / 2 - 1;
  localparam int unsigned CntW    = $clog2(STABLE_FRAMES + 1);
  localparam int unsigned PW      = N + 16;

  typedef enum logic [2:0] {StIdle, StScan, StDrain, StCalc, StReport} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    addr_q, addr_d;
  logic [N-1:0]    bin_q;
  logic            rd_vld_q;

  logic [N-1:0]    wbin_q [NPEAKS];
  logic [N-1:0]    wbin_d [NPEAKS];
  logic [MW-1:0]   wmag_q [NPEAKS];
  logic [MW-1:0]   wmag_d [NPEAKS];
  logic [2:0]      wcnt_q, wcnt_d;

  logic [2:0]                 pcnt_q, pcnt_d;
  logic [NPEAKS*N-1:0]        pbin_q, pbin_d;
  logic [NPEAKS*MW-1:0]       pmag_q, pmag_d;
  logic [MW-1:0]              freq_q, freq_d;
  logic                       stable_q, stable_d;
  logic [CntW-1:0]            stab_q, stab_d;
  logic [N-1:0]               prev_bin_q, prev_bin_d;
  logic                       prev_vld_q, prev_vld_d;

  logic [BIT_WIDTH-1:0] re, im;
  logic [MW-1:0]        abs_re, abs_im, mag;
  logic                 ins_hit, ins_en;
  int                   ins_pos;
  logic [PW-1:0]        prod;

  assign re = fft_result[2*BIT_WIDTH-1:BIT_WIDTH];
  assign im = fft_result[BIT_WIDTH-1:0];

  // Widen by one bit before negating so -2^(BIT_WIDTH-1) yields its exact magnitude.
  always_comb begin
    abs_re = re[BIT_WIDTH-1] ? (MW'(0) - {re[BIT_WIDTH-1], re}) : {1'b0, re};
    abs_im = im[BIT_WIDTH-1] ? (MW'(0) - {im[BIT_WIDTH-1], im}) : {1'b0, im};
    mag    = abs_re + abs_im;
  end

  // First slot that is empty or strictly weaker; equal magnitudes keep the earlier bin ahead.
  always_comb begin
    ins_hit = 1'b0;
    ins_pos = NPEAKS;
    for (int k = 0; k < NPEAKS; k++) begin
      if (!ins_hit && ((3'(k) >= wcnt_q) || (mag > wmag_q[k]))) begin
        ins_hit = 1'b1;
        ins_pos = k;
      end
    end
    ins_en = rd_vld_q && (mag >= MW'(THRESH)) && ins_hit;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wbin_d  = wbin_q;
    wmag_d  = wmag_q;
    wcnt_d  = wcnt_q;

    if (ins_en) begin
      for (int j = 1; j < NPEAKS; j++) begin
        if (j > ins_pos) begin
          wbin_d[j] = wbin_q[j-1];
          wmag_d[j] = wmag_q[j-1];
        end
      end
      for (int j = 0; j < NPEAKS; j++) begin
        if (j == ins_pos) begin
          wbin_d[j] = bin_q;
          wmag_d[j] = mag;
        end
      end
      if (wcnt_q < 3'(NPEAKS)) wcnt_d = wcnt_q + 3'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (fft_done) begin
          state_d = StScan;
          addr_d  = N'(MIN_BIN);
          wcnt_d  = '0;
          for (int j = 0; j < NPEAKS; j++) begin
            wbin_d[j] = '0;
            wmag_d[j] = '0;
          end
        end
      end
      StScan: begin
        addr_d = addr_q + 1'b1;
        if (addr_q == N'(LastBin)) state_d = StDrain;
      end
      StDrain:  state_d = StCalc;
      StCalc:   state_d = StReport;
      StReport: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Published results are loaded on the CALC->REPORT edge so they are visible with peak_valid.
  always_comb begin
    pcnt_d     = pcnt_q;
    pbin_d     = pbin_q;
    pmag_d     = pmag_q;
    freq_d     = freq_q;
    stable_d   = stable_q;
    stab_d     = stab_q;
    prev_bin_d = prev_bin_q;
    prev_vld_d = prev_vld_q;
    prod       = PW'(wbin_q[0]) * PW'(FS);

    if (state_q == StCalc) begin
      for (int k = 0; k < NPEAKS; k++) begin
        pbin_d[k*N +: N]   = wbin_q[k];
        pmag_d[k*MW +: MW] = wmag_q[k];
      end
      pcnt_d = wcnt_q;
      freq_d = (wcnt_q == 3'd0) ? '0 : MW'(prod >> N);
      if (wcnt_q == 3'd0) begin
        stab_d = '0;
      end else if (prev_vld_q && (wbin_q[0] == prev_bin_q)) begin
        stab_d = (stab_q == CntW'(STABLE_FRAMES)) ? stab_q : stab_q + 1'b1;
      end else begin
        stab_d = CntW'(1);
      end
      stable_d   = (stab_d == CntW'(STABLE_FRAMES));
      prev_bin_d = wbin_q[0];
      prev_vld_d = (wcnt_q != 3'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      bin_q      <= '0;
      rd_vld_q   <= 1'b0;
      wcnt_q     <= '0;
      for (int k = 0; k < NPEAKS; k++) begin
        wbin_q[k] <= '0;
        wmag_q[k] <= '0;
      end
      pcnt_q     <= '0;
      pbin_q     <= '0;
      pmag_q     <= '0;
      freq_q     <= '0;
      stable_q   <= 1'b0;
      stab_q     <= '0;
      prev_bin_q <= '0;
      prev_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      bin_q      <= addr_q;
      rd_vld_q   <= (state_q == StScan);
      wcnt_q     <= wcnt_d;
      wbin_q     <= wbin_d;
      wmag_q     <= wmag_d;
      pcnt_q     <= pcnt_d;
      pbin_q     <= pbin_d;
      pmag_q     <= pmag_d;
      freq_q     <= freq_d;
      stable_q   <= stable_d;
      stab_q     <= stab_d;
      prev_bin_q <= prev_bin_d;
      prev_vld_q <= prev_vld_d;
    end
  end

  assign add_rd     = (state_q == StScan) ? addr_q : '0;
  assign busy       = (state_q != StIdle);
  assign peak_valid = (state_q == StReport);
  assign peak_count = pcnt_q;
  assign peak_bin   = pbin_q;
  assign peak_mag   = pmag_q;
  assign frequency  = freq_q;
  assign stable     = stable_q;

endmodule
